// File: rtl/bmem_pkg.sv
// rtl/bmem_pkg.sv - shared types and constants for the burst memory line adapter
package bmem_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        WR_BURST
    } adapter_state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } line_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] rdata;
    } line_resp_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:5], 5'b0};
    endfunction

endpackage

// File: rtl/bmem_burst_assembler.sv
// rtl/bmem_burst_assembler.sv - reassembles returning read bursts into tagged lines
module bmem_burst_assembler
    import bmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rvalid,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [BEAT_W-1:0] i_rdata,
    input  logic              i_pending,
    output logic              o_burst_done,
    output logic              o_resp_valid,
    output line_resp_t        o_resp,
    output logic              o_err
);

    logic [1:0]                  r_rbeat;
    logic [ADDR_W-1:0]           r_raddr;
    logic [LINE_W-BEAT_W-1:0]    r_line;
    logic                        r_resp_valid;
    line_resp_t                  r_resp;
    logic                        r_err;

    logic w_beat;
    logic w_last;
    logic w_addr_bad;
    logic w_gap;
    logic w_stray;

    // Beats arriving with nothing outstanding are dropped rather than assembled.
    assign w_beat     = i_rvalid && i_pending;
    assign w_last     = w_beat && (r_rbeat == 2'd3);
    assign w_addr_bad = w_beat && (r_rbeat != 2'd0) && (i_raddr != r_raddr);
    assign w_gap      = !i_rvalid && (r_rbeat != 2'd0);
    assign w_stray    = i_rvalid && !i_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbeat      <= 2'd0;
            r_raddr      <= '0;
            r_line       <= '0;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= w_last;
            if (w_beat) begin
                r_rbeat <= r_rbeat + 2'd1;
                if (r_rbeat == 2'd0) begin
                    r_raddr <= i_raddr;
                end
                if (!w_last) begin
                    r_line[r_rbeat*BEAT_W +: BEAT_W] <= i_rdata;
                end
            end
            if (w_last) begin
                r_resp <= '{addr: r_raddr, rdata: {i_rdata, r_line}};
            end
            if (w_addr_bad || w_gap || w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_burst_done = w_last;
    assign o_resp_valid = r_resp_valid;
    assign o_resp       = r_resp;
    assign o_err        = r_err;

endmodule

// File: rtl/bmem_line_adapter.sv
// rtl/bmem_line_adapter.sv - cache-line to 4-beat burst initiator for the banked memory port
module bmem_line_adapter
    import bmem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BEATS           = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              wr_done,
    output logic              err,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    adapter_state_t          r_state;
    adapter_state_t          w_next;
    logic                    r_rst_done;
    logic [ADDR_W-1:0]       r_addr;
    logic [LINE_W-1:0]       r_wdata;
    logic [BEAT_IDX_W-1:0]   r_beat;
    logic [3:0]              r_outstanding;
    logic                    r_wr_done;

    line_req_t               w_req;
    line_resp_t              w_resp;
    logic                    w_req_ok;
    logic                    w_req_fire;
    logic                    w_rd_fire;
    logic                    w_wr_beat;
    logic                    w_wr_last;
    logic                    w_burst_done;

    assign w_req = '{we: req_we, addr: line_align(req_addr), wdata: req_wdata};

    // Writes wait for every read to drain; reads only respect the credit limit.
    // r_rst_done keeps req_ready low while reset is asserted.
    assign w_req_ok   = (r_state == IDLE) && r_rst_done &&
                        (w_req.we ? (r_outstanding == 4'd0)
                                  : (r_outstanding < 4'(MAX_OUTSTANDING)));
    assign w_req_fire = req_valid && w_req_ok;
    assign w_rd_fire  = (r_state == RD_REQ) && bmem_ready;
    assign w_wr_beat  = (r_state == WR_BURST) && bmem_ready;
    assign w_wr_last  = w_wr_beat && (r_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_next = w_req.we ? WR_BURST : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    w_next = IDLE;
                end
            end
            WR_BURST: begin
                if (w_wr_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_beat        <= '0;
            r_outstanding <= 4'd0;
            r_wr_done     <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_wr_done  <= w_wr_last;
            if (w_req_fire) begin
                r_addr <= w_req.addr;
                r_beat <= '0;
                if (w_req.we) begin
                    r_wdata <= w_req.wdata;
                end
            end else if (w_wr_beat && !w_wr_last) begin
                r_beat <= r_beat + 1'b1;
            end
            // A coinciding issue and burst completion leaves the count unchanged.
            case ({w_rd_fire, w_burst_done})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    bmem_burst_assembler u_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rvalid     (bmem_rvalid),
        .i_raddr      (bmem_raddr),
        .i_rdata      (bmem_rdata),
        .i_pending    (r_outstanding != 4'd0),
        .o_burst_done (w_burst_done),
        .o_resp_valid (resp_valid),
        .o_resp       (w_resp),
        .o_err        (err)
    );

    assign req_ready  = w_req_ok;
    assign resp_addr  = w_resp.addr;
    assign resp_rdata = w_resp.rdata;
    assign wr_done    = r_wr_done;
    assign bmem_read  = (r_state == RD_REQ);
    assign bmem_write = (r_state == WR_BURST);
    assign bmem_addr  = (r_state != IDLE) ? r_addr : '0;
    assign bmem_wdata = (r_state == WR_BURST) ? r_wdata[r_beat*BEAT_W +: BEAT_W] : '0;

endmodule
